// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b computed LSB-first through one full-adder cell as a + ~b + 1.
// Operands and result move on independent valid/ready handshakes.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

  state_t            r_state;
  logic [WIDTH-1:0]  r_op_a;
  logic [WIDTH-1:0]  r_op_b;
  logic [WIDTH-1:0]  r_res;
  logic              r_carry;
  logic [CntW-1:0]   r_cnt;
  logic              r_a_msb;
  logic              r_b_msb;
  logic [WIDTH-1:0]  r_diff;
  logic              r_borrow;
  logic              r_overflow;
  logic              r_out_valid;

  logic              w_s;
  logic              w_cout;
  logic [WIDTH-1:0]  w_res_next;
  logic              w_last;

  // Full-adder cell on the current LSBs; opB already holds ~b.
  assign w_s        = r_op_a[0] ^ r_op_b[0] ^ r_carry;
  assign w_cout     = (r_op_a[0] & r_op_b[0]) | (r_op_a[0] & r_carry) | (r_op_b[0] & r_carry);
  assign w_res_next = {w_s, r_res[WIDTH-1:1]};
  assign w_last     = (r_cnt == CntW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_a_msb     <= 1'b0;
      r_b_msb     <= 1'b0;
      r_diff      <= '0;
      r_borrow    <= 1'b0;
      r_overflow  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (in_valid) begin
            r_op_a  <= a;
            r_op_b  <= ~b;
            r_carry <= 1'b1;
            r_cnt   <= '0;
            r_a_msb <= a[WIDTH-1];
            r_b_msb <= b[WIDTH-1];
            r_state <= StRun;
          end
        end
        StRun: begin
          r_op_a  <= r_op_a >> 1;
          r_op_b  <= r_op_b >> 1;
          r_res   <= w_res_next;
          r_carry <= w_cout;
          r_cnt   <= r_cnt + CntW'(1);
          if (w_last) begin
            // w_s here is the result MSB; overflow only when operand signs differ.
            r_diff      <= w_res_next;
            r_borrow    <= ~w_cout;
            r_overflow  <= (r_a_msb != r_b_msb) & (w_s != r_a_msb);
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign in_ready  = (r_state == StIdle);
  assign out_valid = r_out_valid;
  assign diff      = r_diff;
  assign borrow    = r_borrow;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8: vector table, output stall, and mid-RUN reset.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         overflow;

  int n_cmp;
  int n_err;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .diff     (diff),
    .borrow   (borrow),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic [W-1:0] exp_diff;
    logic         exp_borrow;
    logic         exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair; returns with the DUT in DONE (or after the bound expires).
  task automatic start_and_wait(input logic [W-1:0] va, input logic [W-1:0] vb, input string tag);
    int lat;
    check({tag, " in_ready idle"}, {31'd0, in_ready}, 32'd1);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    a        = '0;
    b        = '0;
    check({tag, " in_ready drop"}, {31'd0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    check({tag, " latency"}, lat, W);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({tag, " out_valid clr"}, {31'd0, out_valid}, 32'd0);
    check({tag, " in_ready back"}, {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;

    vecs[0] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1};
    vecs[3] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1};
    vecs[4] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0};
    vecs[6] = '{8'h00, 8'h80, 8'h80, 1'b1, 1'b1};
    vecs[7] = '{8'hFF, 8'h01, 8'hFE, 1'b0, 1'b0};

    #2;
    check("rst in_ready", {31'd0, in_ready}, 32'd1);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst diff", {24'd0, diff}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      start_and_wait(vecs[i].va, vecs[i].vb, tag);
      check({tag, " diff"}, {24'd0, diff}, {24'd0, vecs[i].exp_diff});
      check({tag, " borrow"}, {31'd0, borrow}, {31'd0, vecs[i].exp_borrow});
      check({tag, " overflow"}, {31'd0, overflow}, {31'd0, vecs[i].exp_ovf});
      drain(tag);
    end

    // Mid-RUN reset: previous diff is nonzero, so the clear is observable.
    check("pre-rst diff", {24'd0, diff}, 32'h0000_00FE);
    a        = 8'h10;
    b        = 8'h01;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst diff", {24'd0, diff}, 32'd0);
    check("midrst borrow", {31'd0, borrow}, 32'd0);
    check("midrst overflow", {31'd0, overflow}, 32'd0);
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    #2;
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 12; i++) begin
        step();
        if (out_valid) seen++;
      end
      check("midrst no output", seen, 0);
    end
    start_and_wait(8'h09, 8'h04, "post-rst");
    check("post-rst diff", {24'd0, diff}, 32'h0000_0005);
    check("post-rst borrow", {31'd0, borrow}, 32'd0);
    drain("post-rst");

    // Output stall: DONE must hold results for as long as out_ready stays low.
    start_and_wait(8'hA5, 8'hA5, "stall");
    for (int i = 0; i < 5; i++) begin
      check("stall out_valid", {31'd0, out_valid}, 32'd1);
      check("stall diff", {24'd0, diff}, 32'd0);
      check("stall borrow", {31'd0, borrow}, 32'd0);
      check("stall overflow", {31'd0, overflow}, 32'd0);
      check("stall in_ready", {31'd0, in_ready}, 32'd0);
      step();
    end
    drain("stall");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned/two's-complement subtractor: computes diff = a - b, one bit per clock, through a single full-adder cell.
- The cell computes a + ~b + 1, the inverse operation of the team's full adder.
- Operands enter on a valid/ready handshake and the result leaves on a second valid/ready handshake.
- Sits in the arithmetic datapath next to the adder blocks, where area matters more than latency.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operands a/b valid.
- in_ready  output  1  block can accept operands (high only in IDLE).
- a  input  WIDTH  minuend; sampled on accept edge only.
- b  input  WIDTH  subtrahend; sampled on accept edge only.
- out_valid  output  1  diff/borrow/overflow valid.
- out_ready  input  1  consumer takes result.
- diff  output  WIDTH  a - b modulo 2^WIDTH.
- borrow  output  1  1 when a < b unsigned; equals inverted final carry.
- overflow  output  1  signed overflow of a - b.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - State goes to IDLE; counter, shift registers and carry clear.
  - out_valid=0, diff=0, borrow=0, overflow=0.
  - in_ready=1 once in IDLE. in_ready is decoded from state, so it is 1 during reset.
- Reset mid-RUN or mid-DONE: the operation is abandoned and produces no output. The first accept after rst_n rises starts clean.
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept edge = rising edge with in_valid & in_ready.
  - On the accept edge: opA<=a, opB<=~b, carry<=1, cnt<=0, save a[WIDTH-1] and b[WIDTH-1]; go to RUN.
  - in_valid low: stay in IDLE.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge, the full-adder cell takes s = opA[0]^opB[0]^carry and cout = majority(opA[0], opB[0], carry).
  - opA and opB shift right by 1. The result register shifts right with s inserted at the MSB. carry<=cout, cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1, go to DONE. Register diff from the completed shift register, borrow<=~cout, overflow<=(a_msb!=b_msb)&(s!=a_msb). out_valid<=1.
  - Latency: out_valid is first high exactly WIDTH edges after the accept edge.
  - in_valid is ignored during RUN and is not captured.
- DONE:
  - out_valid=1; diff/borrow/overflow held stable while out_ready=0, for unbounded stall.
  - in_ready=0.
  - Edge with out_ready=1: out_valid<=0 and go to IDLE. The earliest next accept is the following edge; there is no same-cycle turnaround.
- Arithmetic rules:
  - diff wraps modulo 2^WIDTH.
  - borrow=1 iff unsigned a<b.
  - overflow follows two's-complement rules and is independent of borrow.
  - a==b gives diff=0, borrow=0, overflow=0.
- Throughput: one result per WIDTH+2 cycles minimum.
- out_ready high outside DONE has no effect.

Test Plan (WIDTH=8):
- Reset, then a=8'h05, b=8'h03, in_valid=1 for one edge:
  - in_ready drops next cycle.
  - out_valid rises exactly 8 edges after accept.
  - diff=8'h02, borrow=0, overflow=0.
- a=8'h03, b=8'h05 -> diff=8'hFE, borrow=1, overflow=0.
- a=8'h80, b=8'h01 -> diff=8'h7F, borrow=0, overflow=1.
- a=8'h7F, b=8'hFF -> diff=8'h80, borrow=1, overflow=1.
- a=b=8'hA5 with out_ready held 0 for 5 cycles after out_valid:
  - diff=0, borrow=0, overflow=0 held stable throughout.
  - in_ready stays 0.
  - Raising out_ready returns to IDLE in one edge.
- Start a=8'h10, b=8'h01, pulse rst_n low at the 4th RUN cycle:
  - Outputs are immediately 0 and in_ready=1.
  - No out_valid appears.
  - A following a=8'h09, b=8'h04 yields diff=8'h05.
